// File: rtl/reg_trace_checker.sv
// reg_trace_checker
//   Compares the register-write strobes of a core under test, in order,
//   against a preloaded table of expected (bank, adr, data) writes and
//   reports pass, or fail with a cause code and the failing step.
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   start, exp_len    begin a run of exp_len entries (clamped to DEPTH)
//   ld_we/idx/entry   expected-table write port, {bank, adr, data}
//   we/wbank/wadr/wdin observed register write
//   fault_in          core fault flag
//   busy              high while a run is active (RUN or DRAIN)
//   pass, fail        sticky result flags
//   fail_code         0 none, 1 mismatch, 2 overrun, 3 timeout, 4 fault
//   step              entries matched so far
//   mism_step/entry   step and observed write at the failure
module reg_trace_checker #(
    parameter int DEPTH   = 16,
    parameter int DW      = 32,
    parameter int AW      = 4,
    parameter int BW      = 1,
    parameter int TIMEOUT = 25000,
    parameter int GUARD   = 64,
    localparam int SW     = $clog2(DEPTH + 1),
    localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int EW     = BW + AW + DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [SW-1:0] exp_len,
    input  logic          ld_we,
    input  logic [IW-1:0] ld_idx,
    input  logic [EW-1:0] ld_entry,
    input  logic          we,
    input  logic [BW-1:0] wbank,
    input  logic [AW-1:0] wadr,
    input  logic [DW-1:0] wdin,
    input  logic          fault_in,
    output logic          busy,
    output logic          pass,
    output logic          fail,
    output logic [2:0]    fail_code,
    output logic [SW-1:0] step,
    output logic [SW-1:0] mism_step,
    output logic [EW-1:0] mism_entry
);

    // One counter serves both the RUN timeout and the DRAIN guard window;
    // it is cleared on entry to each state.
    localparam int CMAX = (TIMEOUT > GUARD) ? TIMEOUT : GUARD;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [2:0] FC_NONE  = 3'd0;
    localparam logic [2:0] FC_MISM  = 3'd1;
    localparam logic [2:0] FC_OVER  = 3'd2;
    localparam logic [2:0] FC_TMO   = 3'd3;
    localparam logic [2:0] FC_FAULT = 3'd4;

    localparam logic [CW-1:0] TO_C  = CW'(TIMEOUT);
    localparam logic [CW-1:0] GD_C  = CW'(GUARD);
    localparam logic [SW-1:0] DEP_C = SW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_PASS,
        S_FAIL
    } state_t;

    // Expected table: no reset, contents persist across runs and resets.
    logic [EW-1:0] mem [DEPTH];

    state_t        state_q, state_n;
    logic [SW-1:0] len_q, len_n;
    logic [SW-1:0] step_q, step_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          pass_q, pass_n;
    logic          fail_q, fail_n;
    logic [2:0]    code_q, code_n;
    logic [SW-1:0] mstep_q, mstep_n;
    logic [EW-1:0] mentry_q, mentry_n;

    logic [EW-1:0] obs;
    logic [EW-1:0] exp_e;
    logic [CW-1:0] cnt_inc;
    logic [SW-1:0] step_inc;
    logic [SW-1:0] len_clamp;
    logic          do_fail;
    logic [2:0]    f_code;
    logic [SW-1:0] f_step;
    logic [EW-1:0] f_entry;

    assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);

    always_ff @(posedge clk) begin
        if (ld_we && !busy) mem[ld_idx] <= ld_entry;
    end

    assign obs       = {wbank, wadr, wdin};
    assign exp_e     = mem[step_q[IW-1:0]];
    assign cnt_inc   = cnt_q + 1'b1;
    assign step_inc  = step_q + 1'b1;
    assign len_clamp = (exp_len > DEP_C) ? DEP_C : exp_len;

    always_comb begin
        state_n  = state_q;
        len_n    = len_q;
        step_n   = step_q;
        cnt_n    = cnt_q;
        pass_n   = pass_q;
        fail_n   = fail_q;
        code_n   = code_q;
        mstep_n  = mstep_q;
        mentry_n = mentry_q;
        do_fail  = 1'b0;
        f_code   = FC_NONE;
        f_step   = step_q;
        f_entry  = obs;

        case (state_q)
            S_RUN: begin
                cnt_n = cnt_inc;
                // Priority: fault > mismatch > timeout > match.
                if (fault_in) begin
                    do_fail = 1'b1;
                    f_code  = FC_FAULT;
                end else if (we && obs != exp_e) begin
                    do_fail = 1'b1;
                    f_code  = FC_MISM;
                end else if (cnt_inc == TO_C) begin
                    do_fail = 1'b1;
                    f_code  = FC_TMO;
                    f_entry = '0;
                end else if (we) begin
                    step_n = step_inc;
                    if (step_inc == len_q) begin
                        state_n = S_DRAIN;
                        cnt_n   = '0;
                    end
                end
            end
            S_DRAIN: begin
                cnt_n = cnt_inc;
                if (fault_in) begin
                    do_fail = 1'b1;
                    f_code  = FC_FAULT;
                end else if (we) begin
                    do_fail = 1'b1;
                    f_code  = FC_OVER;
                    f_step  = len_q;
                end else if (cnt_inc == GD_C) begin
                    state_n = S_PASS;
                    pass_n  = 1'b1;
                end
            end
            default: begin
                // IDLE, PASS, FAIL: only an accepted start does anything.
                if (start) begin
                    len_n    = len_clamp;
                    step_n   = '0;
                    cnt_n    = '0;
                    pass_n   = 1'b0;
                    fail_n   = 1'b0;
                    code_n   = FC_NONE;
                    mstep_n  = '0;
                    mentry_n = '0;
                    state_n  = (len_clamp == '0) ? S_DRAIN : S_RUN;
                end
            end
        endcase

        if (do_fail) begin
            state_n  = S_FAIL;
            fail_n   = 1'b1;
            code_n   = f_code;
            mstep_n  = f_step;
            mentry_n = f_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            step_q   <= '0;
            cnt_q    <= '0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            code_q   <= FC_NONE;
            mstep_q  <= '0;
            mentry_q <= '0;
        end else begin
            state_q  <= state_n;
            len_q    <= len_n;
            step_q   <= step_n;
            cnt_q    <= cnt_n;
            pass_q   <= pass_n;
            fail_q   <= fail_n;
            code_q   <= code_n;
            mstep_q  <= mstep_n;
            mentry_q <= mentry_n;
        end
    end

    assign pass       = pass_q;
    assign fail       = fail_q;
    assign fail_code  = code_q;
    assign step       = step_q;
    assign mism_step  = mstep_q;
    assign mism_entry = mentry_q;

endmodule
